multiaddr_expand: RTL and testbench

//   Expands one multi-address set {addr, mask} into its individual addresses, one per beat.
//   Set bits in mask are don't-cares, so a set holds 2^popcount(mask) addresses.

---
 rtl/multiaddr_expand.sv | 104 ++++++++++
 tb/tb_multiaddr_expand.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiaddr_expand.sv
// multiaddr_expand
//   Expands one multi-address set {addr, mask} into its unicast addresses, one per output beat.
//   Bits set in the mask are don't-cares. A set therefore holds 2^popcount(mask) addresses.
//   The addresses are enumerated in ascending numeric order, and the last beat of a set is flagged.
//   Ports:
//     clk_i, rst_ni              clock, synchronous active-low reset
//     valid_i/ready_o            input set handshake
//     addr_i, mask_i             set address and don't-care mask
//     valid_o/ready_i            output beat handshake
//     addr_o, last_o, beat_o     current unicast address, final-beat flag, 0-based beat index
//     busy_o                     expansion in progress
module multiaddr_expand #(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] mask_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 last_o,
    output logic [AddrWidth-1:0] beat_o,
    output logic                 busy_o
);

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    state_e               r_state, w_state_d;
    logic [AddrWidth-1:0] r_base, w_base_d;
    logic [AddrWidth-1:0] r_mask, w_mask_d;
    logic [AddrWidth-1:0] r_cur, w_cur_d;
    logic [AddrWidth-1:0] r_beat, w_beat_d;
    logic                 w_last;
    logic [AddrWidth-1:0] w_cur_inc;

    // All masked bits set means the masked-bit counter is at its maximum.
    assign w_last = ((r_cur & r_mask) == r_mask);

    // Forcing the unmasked bits to 1 lets the carry ripple straight through them to the next
    // masked bit. Re-masking and OR-ing with the base then restores the fixed bits.
    assign w_cur_inc = (((r_cur | ~r_mask) + AddrWidth'(1)) & r_mask) | r_base;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_base  <= '0;
            r_mask  <= '0;
            r_cur   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_d;
            r_base  <= w_base_d;
            r_mask  <= w_mask_d;
            r_cur   <= w_cur_d;
            r_beat  <= w_beat_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_base_d  = r_base;
        w_mask_d  = r_mask;
        w_cur_d   = r_cur;
        w_beat_d  = r_beat;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        last_o    = 1'b0;

        unique case (r_state)
            StIdle: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_base_d  = addr_i & ~mask_i;
                    w_mask_d  = mask_i;
                    w_cur_d   = addr_i & ~mask_i;
                    w_beat_d  = '0;
                    w_state_d = StExpand;
                end
            end
            StExpand: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                last_o  = w_last;
                if (ready_i) begin
                    if (w_last) begin
                        w_state_d = StIdle;
                    end else begin
                        w_cur_d  = w_cur_inc;
                        w_beat_d = r_beat + AddrWidth'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign addr_o = r_cur;
    assign beat_o = r_beat;

endmodule

// File: tb/tb_multiaddr_expand.sv
// Testbench for multiaddr_expand: a scoreboard checks every output beat against a reference
// enumeration of each set. Directed cases come first, then randomized sets with random
// backpressure.
module tb_multiaddr_expand;

    localparam int unsigned AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic          ready_o;
    logic [AW-1:0] addr_i;
    logic [AW-1:0] mask_i;
    logic          valid_o;
    logic          ready_i;
    logic [AW-1:0] addr_o;
    logic          last_o;
    logic [AW-1:0] beat_o;
    logic          busy_o;

    multiaddr_expand #(.AddrWidth(AW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .addr_i  (addr_i),
        .mask_i  (mask_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .addr_o  (addr_o),
        .last_o  (last_o),
        .beat_o  (beat_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [AW-1:0] beat;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_err = 0;

    // Ready control: forced value or random backpressure.
    logic rdy_force = 1'b1;
    logic rdy_val   = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the k-th address deposits the bits of k, LSB first, into the masked positions.
    task automatic push_expected(input logic [AW-1:0] a, input logic [AW-1:0] m);
        logic [AW-1:0] base;
        logic [AW-1:0] cur;
        int            n;
        int            idx;
        base = a & ~m;
        n = $countones(m);
        for (int unsigned k = 0; k < (32'd1 << n); k++) begin
            cur = base;
            idx = 0;
            for (int b = 0; b < AW; b++) begin
                if (m[b]) begin
                    cur[b] = k[idx];
                    idx++;
                end
            end
            sb.push_back('{addr: cur, beat: AW'(k), last: (k == (32'd1 << n) - 1)});
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge. Returns 1 time unit after the
    // accepting edge, which is when the first beat is visible.
    task automatic send_set(input logic [AW-1:0] a, input logic [AW-1:0] m);
        int cnt;
        cnt = 0;
        addr_i  = a;
        mask_i  = m;
        valid_i = 1'b1;
        while (!ready_o && cnt < 5000) begin
            @(posedge clk_i);
            #1;
            cnt++;
        end
        if (!ready_o) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: ready_o=%0b required 1", ready_o);
        end
        push_expected(a, m);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        // Scramble the inputs to show that the burst does not depend on them after acceptance.
        addr_i  = $urandom;
        mask_i  = $urandom;
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((sb.size() != 0 || !ready_o) && cnt < 5000) begin
            @(posedge clk_i);
            #1;
            cnt++;
        end
        chk("drain_left", AW'(sb.size()), '0);
        chk("drain_idle", AW'(ready_o), AW'(1));
    endtask

    function automatic logic [AW-1:0] rand_mask();
        logic [AW-1:0] m;
        int            nb;
        m  = '0;
        nb = $urandom_range(0, 5);
        for (int i = 0; i < nb; i++) m[$urandom_range(0, AW - 1)] = 1'b1;
        return m;
    endfunction

    // Ready driver.
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            ready_i = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops one expected beat per output handshake and checks stall stability.
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] prev_beat;
    logic          prev_last;

    always @(negedge clk_i) begin
        beat_t e;
        if (rst_ni) begin
            if (prev_stall) begin
                chk("hold_valid", AW'(valid_o), AW'(1));
                chk("hold_addr", addr_o, prev_addr);
                chk("hold_beat", beat_o, prev_beat);
                chk("hold_last", AW'(last_o), AW'(prev_last));
            end
            if (valid_o) begin
                chk("busy_with_valid", AW'({busy_o, ready_o}), AW'(2'b10));
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_beat: addr_o=0x%0h with no beat expected", addr_o);
                end else begin
                    e = sb.pop_front();
                    chk("beat_addr", addr_o, e.addr);
                    chk("beat_index", beat_o, e.beat);
                    chk("beat_last", AW'(last_o), AW'(e.last));
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_addr  = addr_o;
            prev_beat  = beat_o;
            prev_last  = last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        addr_i  = '0;
        mask_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("rst_valid", AW'(valid_o), '0);
        chk("rst_ready", AW'(ready_o), AW'(1));
        chk("rst_addr", addr_o, '0);
        chk("rst_last", AW'(last_o), '0);
        chk("rst_beat", beat_o, '0);
        chk("rst_busy", AW'(busy_o), '0);

        // Single beat, then one idle cycle with ready_o high.
        rdy_val = 1'b1;
        send_set(32'h1234, 32'h0);
        chk("single_addr", addr_o, 32'h1234);
        chk("single_last", AW'(last_o), AW'(1));
        chk("single_beat", beat_o, '0);
        @(posedge clk_i);
        #1;
        chk("single_ready_after", AW'(ready_o), AW'(1));
        chk("single_valid_after", AW'(valid_o), '0);

        send_set(32'h100, 32'h3);
        wait_drain();
        send_set(32'h0, 32'h11);
        wait_drain();
        send_set(32'h107, 32'h3);
        chk("first_beat_0x107", addr_o, 32'h104);
        wait_drain();

        // Backpressure at beat 1.
        send_set(32'h100, 32'h3);
        @(posedge clk_i);
        #1;
        rdy_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk("bp_addr", addr_o, 32'h101);
            chk("bp_valid", AW'(valid_o), AW'(1));
            chk("bp_beat", beat_o, AW'(1));
        end
        rdy_val = 1'b1;
        wait_drain();

        // Reset during beat 2 of a 4-beat set.
        send_set(32'h200, 32'h3);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        chk("pre_rst_beat", beat_o, AW'(2));
        rdy_val = 1'b0;
        rst_ni  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("midrst_valid", AW'(valid_o), '0);
        chk("midrst_ready", AW'(ready_o), AW'(1));
        chk("midrst_busy", AW'(busy_o), '0);
        sb.delete();
        rdy_val = 1'b1;
        send_set(32'h40, 32'h1);
        chk("after_rst_first", addr_o, 32'h40);
        wait_drain();

        // Randomized sets with random backpressure.
        rdy_force = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send_set($urandom, rand_mask());
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();
        repeat (2) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
